instruction_fetch_controller: RTL and testbench
===============================================

INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk (rising edge), rst (asynchronous, active-high).
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 run  input  1  level; 1 = fetch and issue instructions, 0 = stop after the current instruction.
REQ-005 imem_rd_en  output  1  instruction-memory read strobe; the memory is synchronous with 1-cycle read latency.
REQ-006 imem_addr  output  5  instruction-memory word address (= pc).
REQ-007 imem_rdata  input  59  memory word; valid in the cycle after imem_rd_en.
REQ-008 decode_start  output  1  start to the decode controller.
REQ-009 instruction  output  59  instruction word to the decode controller.
REQ-010 decode_busy  input  1  decode controller busy.
REQ-011 decode_done  input  1  decode controller done.
REQ-012 fetch_stage_enable  input  1  decode poll flag; 1 = ready for the next fetch.
REQ-013 next_pc  input  5  next PC returned by decode.
REQ-014 pc  output  5  current program counter.
REQ-015 halted  output  1  a HALT opcode or a timeout has been reached.
REQ-016 timeout_err  output  1  decode handshake timeout flag.
REQ-017 fetch_count  output  16  number of instructions issued.

Function
REQ-018 States: IDLE, FETCH, CAPTURE, ISSUE, WAIT, HALTED.
REQ-019 IDLE: if run=1, go to FETCH; otherwise remain in IDLE.
REQ-020 FETCH: imem_rd_en=1 for exactly one cycle with imem_addr=pc, then go to CAPTURE.
REQ-021 CAPTURE: latch imem_rdata into the instruction register, overwriting bits [36:32] with pc; the remaining bits pass unchanged.
- If the latched opcode [56:52] = 5'd31 (HALT): set halted=1, go to HALTED, and do not issue.
- Otherwise go to ISSUE.
REQ-022 ISSUE: hold decode_start=1 and instruction stable until decode_busy=1 is sampled.
- Then deassert decode_start in the next cycle, increment fetch_count, and go to WAIT.
REQ-023 WAIT: when decode_done=1 and decode_busy=0 and fetch_stage_enable=1 are sampled together, load pc<=next_pc.
- Then go to FETCH if run=1, else IDLE.
REQ-024 instruction SHALL remain stable from CAPTURE until the WAIT exit.
REQ-025 PC arithmetic is 5-bit; next_pc=0 after pc=31 is legal and SHALL NOT be treated as an error.
REQ-026 fetch_count SHALL wrap 16'hFFFF -> 0.
REQ-027 run falling during FETCH, CAPTURE, ISSUE or WAIT SHALL NOT abort the instruction; the block returns to IDLE after the WAIT exit.
REQ-028 HALTED is terminal; only rst leaves it.
REQ-029 decode_done asserted outside WAIT SHALL be ignored.
REQ-030 Fetch-to-issue latency: decode_start rises 2 cycles after imem_rd_en.

Reset
REQ-031 Asserting rst at any time, including mid-instruction, SHALL immediately force:
- state = IDLE
- pc = 0, fetch_count = 0, instruction = 0
- imem_rd_en = 0, decode_start = 0, halted = 0, timeout_err = 0
REQ-032 After rst deasserts, the first fetch SHALL occur from address 0.

Configuration
REQ-033 Macro FETCH_TIMEOUT_EN.
- Defined: an 8-bit watchdog counts cycles spent in ISSUE plus WAIT, and clears on each state entry into ISSUE.
- At count 255 it sets timeout_err=1 and halted=1, deasserts decode_start, and goes to HALTED.
- Undefined: no watchdog; timeout_err is tied to 0 and ISSUE/WAIT wait indefinitely.

Verification
REQ-034 Reset, run=1, mem[0] = ADD opcode, decode answers busy after 1 cycle and done after 3 cycles, next_pc=1 -> instruction[36:32]=0, fetch_count=1, next imem_addr=1.
REQ-035 mem[31]=ADD, pc forced to 31 via the sequence, next_pc=0 -> pc wraps to 0 and fetch continues; halted=0.
REQ-036 mem[2] opcode 31 -> halted=1 two cycles after imem_rd_en, decode_start never rises, fetch_count unchanged.
REQ-037 run dropped during WAIT -> block completes on done, pc=next_pc, state IDLE, imem_rd_en stays 0.
REQ-038 rst asserted in ISSUE with decode_start=1 -> decode_start=0 and pc=0 asynchronously, before the next clk edge.
REQ-039 FETCH_TIMEOUT_EN defined, decode_busy held 0 -> timeout_err=1 and halted=1 after 255 cycles in ISSUE; with the macro undefined, the block stays in ISSUE and timeout_err=0.

Source files
------------

// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - fetches words from a 1-cycle synchronous imem and hands them to decode
// Optional decode-handshake watchdog enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_rd_en,
  output logic [4:0]  imem_addr,
  input  logic [58:0] imem_rdata,
  output logic        decode_start,
  output logic [58:0] instruction,
  input  logic        decode_busy,
  input  logic        decode_done,
  input  logic        fetch_stage_enable,
  input  logic [4:0]  next_pc,
  output logic [4:0]  pc,
  output logic        halted,
  output logic        timeout_err,
  output logic [15:0] fetch_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_ISSUE   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_HALTED  = 3'd5;

  localparam logic [4:0] OP_HALT = 5'd31;

  logic [2:0] state;
  logic       wd_expire;
  logic       wait_exit;

  // Strobes decode straight from state so rst clears them without waiting for a clock edge.
  assign imem_rd_en   = (state == S_FETCH);
  assign imem_addr    = pc;
  assign decode_start = (state == S_ISSUE);
  assign wait_exit    = decode_done && !decode_busy && fetch_stage_enable;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wdog;
  logic       timeout_q;

  // Expires on the cycle that takes the count to 255.
  assign wd_expire   = (wdog == 8'd254) && ((state == S_ISSUE) || (state == S_WAIT));
  assign timeout_err = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog      <= 8'd0;
      timeout_q <= 1'b0;
    end else if (state == S_CAPTURE) begin
      wdog <= 8'd0;
    end else if ((state == S_ISSUE) || (state == S_WAIT)) begin
      wdog <= wdog + 8'd1;
      if (wd_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= 5'd0;
      instruction <= 59'd0;
      fetch_count <= 16'd0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // The pc field of the word is replaced so decode sees where it came from.
          instruction <= {imem_rdata[58:37], pc, imem_rdata[31:0]};
          if (imem_rdata[56:52] == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALTED;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (wd_expire) begin
            halted <= 1'b1;
            state  <= S_HALTED;
          end else if (decode_busy) begin
            fetch_count <= fetch_count + 16'd1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wd_expire) begin
            halted <= 1'b1;
            state  <= S_HALTED;
          end else if (wait_exit) begin
            pc    <= next_pc;
            state <= run ? S_FETCH : S_IDLE;
          end
        end
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// tb/tb_instruction_fetch_controller.sv - directed vector bench for instruction_fetch_controller
module tb_instruction_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_rd_en;
  logic [4:0]  imem_addr;
  logic [58:0] imem_rdata;
  logic        decode_start;
  logic [58:0] instruction;
  logic        decode_busy;
  logic        decode_done;
  logic        fetch_stage_enable;
  logic [4:0]  next_pc;
  logic [4:0]  pc;
  logic        halted;
  logic        timeout_err;
  logic [15:0] fetch_count;

  logic [58:0] mem [32];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  pc;
    logic [4:0]  op;
    logic [4:0]  npc;
    logic [15:0] exp_count;
  } vec_t;

  vec_t tv [4];

  instruction_fetch_controller dut (
    .clk                (clk),
    .rst                (rst),
    .run                (run),
    .imem_rd_en         (imem_rd_en),
    .imem_addr          (imem_addr),
    .imem_rdata         (imem_rdata),
    .decode_start       (decode_start),
    .instruction        (instruction),
    .decode_busy        (decode_busy),
    .decode_done        (decode_done),
    .fetch_stage_enable (fetch_stage_enable),
    .next_pc            (next_pc),
    .pc                 (pc),
    .halted             (halted),
    .timeout_err        (timeout_err),
    .fetch_count        (fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [58:0] mk_word(input logic [4:0] op, input logic [4:0] tag);
    return {2'b11, op, 15'h2AAA, 5'h1F, 27'h5EAD000, tag};
  endfunction

  function automatic logic [58:0] with_pc(input logic [58:0] w, input logic [4:0] p);
    logic [58:0] r;
    r = w;
    r[36:32] = p;
    return r;
  endfunction

  // Waits for the read strobe, checks its address, then checks decode_start follows 2 cycles later.
  task automatic fetch_to_issue(input logic [4:0] exp_addr);
    int k;
    int lat;
    k = 0;
    while (!imem_rd_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rd_en_seen", {63'd0, imem_rd_en}, 64'd1);
    chk("imem_addr", {59'd0, imem_addr}, {59'd0, exp_addr});
    lat = 0;
    while (!decode_start && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("issue_latency", lat, 2);
  endtask

  // Called at a negedge with decode_start high: busy after 1 cycle, done after 3.
  task automatic do_decode(input logic [4:0] npc, input bit drop_run);
    @(negedge clk);
    decode_busy = 1'b1;
    @(negedge clk);
    chk("start_dropped", {63'd0, decode_start}, 64'd0);
    if (drop_run) run = 1'b0;
    @(negedge clk);
    decode_busy        = 1'b0;
    decode_done        = 1'b1;
    fetch_stage_enable = 1'b1;
    next_pc            = npc;
    @(negedge clk);
    decode_done        = 1'b0;
    fetch_stage_enable = 1'b0;
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 32; i++) mem[i] = mk_word(5'd1, i[4:0]);
    mem[1] = mk_word(5'd2, 5'd1);
    mem[2] = mk_word(5'd31, 5'd2);

    tv[0] = '{pc: 5'd0,  op: 5'd1, npc: 5'd1,  exp_count: 16'd1};
    tv[1] = '{pc: 5'd1,  op: 5'd2, npc: 5'd31, exp_count: 16'd2};
    tv[2] = '{pc: 5'd31, op: 5'd1, npc: 5'd0,  exp_count: 16'd3};
    tv[3] = '{pc: 5'd0,  op: 5'd1, npc: 5'd2,  exp_count: 16'd4};

    rst = 1'b1; run = 1'b0; decode_busy = 1'b0; decode_done = 1'b0;
    fetch_stage_enable = 1'b0; next_pc = 5'd0; imem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_pc", {59'd0, pc}, 64'd0);
    chk("rst_count", {48'd0, fetch_count}, 64'd0);
    chk("rst_instr", {5'd0, instruction}, 64'd0);
    chk("rst_rd_en", {63'd0, imem_rd_en}, 64'd0);
    chk("rst_start", {63'd0, decode_start}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_timeout", {63'd0, timeout_err}, 64'd0);
    rst = 1'b0;
    run = 1'b1;

    for (int i = 0; i < 4; i++) begin
      fetch_to_issue(tv[i].pc);
      chk("instruction", {5'd0, instruction},
          {5'd0, with_pc(mk_word(tv[i].op, tv[i].pc), tv[i].pc)});
      do_decode(tv[i].npc, 1'b0);
      chk("pc_after", {59'd0, pc}, {59'd0, tv[i].npc});
      chk("fetch_count", {48'd0, fetch_count}, {48'd0, tv[i].exp_count});
      chk("not_halted", {63'd0, halted}, 64'd0);
    end

    // HALT opcode at address 2
    chk("halt_rd_addr", {58'd0, imem_rd_en, imem_addr}, {58'd0, 1'b1, 5'd2});
    @(negedge clk);
    chk("halt_capture", {63'd0, halted}, 64'd0);
    @(negedge clk);
    chk("halt_set", {63'd0, halted}, 64'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (decode_start || imem_rd_en) seen++;
    end
    chk("halt_quiet", seen, 0);
    chk("halt_count", {48'd0, fetch_count}, 64'd4);
    chk("halt_pc", {59'd0, pc}, 64'd2);

    // run dropped in WAIT, plus decode_done ignored while in ISSUE
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("halt_cleared", {63'd0, halted}, 64'd0);
    fetch_to_issue(5'd0);
    decode_done = 1'b1; fetch_stage_enable = 1'b1; next_pc = 5'd9;
    @(negedge clk);
    chk("done_ignored_start", {63'd0, decode_start}, 64'd1);
    chk("done_ignored_pc", {59'd0, pc}, 64'd0);
    decode_done = 1'b0; fetch_stage_enable = 1'b0;
    do_decode(5'd5, 1'b1);
    chk("rundrop_pc", {59'd0, pc}, 64'd5);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (imem_rd_en) seen++;
      @(negedge clk);
    end
    chk("rundrop_idle", seen, 0);

    // asynchronous reset while decode_start is high
    run = 1'b1;
    fetch_to_issue(5'd5);
    #2 rst = 1'b1;
    #1;
    chk("async_start", {63'd0, decode_start}, 64'd0);
    chk("async_pc", {59'd0, pc}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    fetch_to_issue(5'd0);

    // decode never answers busy
`ifdef FETCH_TIMEOUT_EN
    repeat (254) @(negedge clk);
    chk("wd_not_yet", {63'd0, halted}, 64'd0);
    @(negedge clk);
    chk("wd_halted", {63'd0, halted}, 64'd1);
    chk("wd_timeout", {63'd0, timeout_err}, 64'd1);
    chk("wd_start", {63'd0, decode_start}, 64'd0);
`else
    repeat (300) @(negedge clk);
    chk("nowd_start", {63'd0, decode_start}, 64'd1);
    chk("nowd_timeout", {63'd0, timeout_err}, 64'd0);
    chk("nowd_halted", {63'd0, halted}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
